// File: rtl/m_multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MA/WB sequencer for the RV32I-subset datapath.
// Drives PC/IR/RF/memory enables, detects halt (write to x30) and memory timeout.
module m_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        w_clock,
    input  logic        w_reset,
    input  logic [4:0]  w_opcode5,
    input  logic [4:0]  w_rd,
    input  logic        w_token,
    input  logic        w_mem_ready,
    output logic        w_mem_req,
    output logic        w_mem_sel,
    output logic        w_mem_we,
    output logic        w_ir_we,
    output logic        w_pc_we,
    output logic        w_pc_sel,
    output logic        w_rf_we,
    output logic [1:0]  w_wb_sel,
    output logic [2:0]  w_state,
    output logic        w_halt,
    output logic        w_error,
    output logic [31:0] r_cycle_count,
    output logic [31:0] r_insn_count
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MA   = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [7:0] r_wait;

    logic w_is_load, w_is_store, w_is_branch, w_is_jal;
    logic w_mem_phase, w_timeout;

    assign w_is_load   = (w_opcode5 == 5'b00000);
    assign w_is_store  = (w_opcode5 == 5'b01000);
    assign w_is_branch = (w_opcode5 == 5'b11000);
    assign w_is_jal    = (w_opcode5 == 5'b11011);

    assign w_mem_phase = (r_state == S_IF) || (r_state == S_MA);
    // Ready on the last allowed cycle still completes the access.
    assign w_timeout   = (r_wait == TMO_LAST) && !w_mem_ready;

    assign w_state = r_state;

    always_ff @(posedge w_clock or posedge w_reset) begin
        if (w_reset) r_state <= S_IF;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IF:   if (w_mem_ready)    w_next = S_ID;
                    else if (w_timeout) w_next = S_ERR;
            S_ID:   w_next = S_EX;
            S_EX:   if (w_is_branch)                  w_next = S_IF;
                    else if (w_is_load || w_is_store) w_next = S_MA;
                    else                              w_next = S_WB;
            S_MA:   if (w_mem_ready)    w_next = w_is_store ? S_IF : S_WB;
                    else if (w_timeout) w_next = S_ERR;
            S_WB:   w_next = (w_rd == 5'd30) ? S_HALT : S_IF;
            S_HALT: w_next = S_HALT;
            S_ERR:  w_next = S_ERR;
            default: w_next = S_IF;
        endcase
    end

    always_comb begin
        w_mem_req = 1'b0;
        w_mem_sel = 1'b0;
        w_mem_we  = 1'b0;
        w_ir_we   = 1'b0;
        w_pc_we   = 1'b0;
        w_pc_sel  = 1'b0;
        w_rf_we   = 1'b0;
        w_wb_sel  = 2'd0;
        w_halt    = 1'b0;
        w_error   = 1'b0;
        case (r_state)
            S_IF: begin
                w_mem_req = 1'b1;
                // Reset holds state at IF; keep the IR from latching meanwhile.
                w_ir_we   = w_mem_ready && !w_reset;
            end
            S_EX: if (w_is_branch) begin
                w_pc_we  = 1'b1;
                w_pc_sel = w_token;
            end
            S_MA: begin
                w_mem_req = 1'b1;
                w_mem_sel = 1'b1;
                w_mem_we  = w_is_store;
                w_pc_we   = w_is_store && w_mem_ready;
            end
            S_WB: begin
                w_rf_we  = 1'b1;
                w_pc_we  = 1'b1;
                w_pc_sel = w_is_jal;
                w_wb_sel = w_is_load ? 2'd1 : (w_is_jal ? 2'd2 : 2'd0);
            end
            S_HALT: w_halt = 1'b1;
            S_ERR: begin
                w_halt  = 1'b1;
                w_error = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge w_clock or posedge w_reset) begin
        if (w_reset) begin
            r_wait        <= 8'd0;
            r_cycle_count <= 32'd0;
            r_insn_count  <= 32'd0;
        end else begin
            if ((w_next == S_IF || w_next == S_MA) && (w_next != r_state))
                r_wait <= 8'd0;
            else if (w_mem_phase && !w_mem_ready)
                r_wait <= r_wait + 8'd1;
            if (r_state != S_HALT && r_state != S_ERR)
                r_cycle_count <= r_cycle_count + 32'd1;
            if (w_pc_we)
                r_insn_count <= r_insn_count + 32'd1;
        end
    end

endmodule

// File: doc/m_multicycle_ctrl.md
# m_multicycle_ctrl

Multi-cycle sequencing controller for the RV32I-subset datapath: the single-cycle core is split into IF/ID/EX/MA/WB steps sharing one memory port. The block drives the enables and selects for the PC, IR, register file, data-memory write and write-back mux. It waits on a memory-ready handshake, detects halt (write to x30) and memory timeout, and keeps cycle and retired-instruction counters. It sits beside the datapath and takes decoded fields from the latched IR.

## Interface

- MEM_TIMEOUT, 16, max cycles waiting on w_mem_ready in IF/MA before error (1..255)

- w_clock  in  1  clock, rising edge
- w_reset  in  1  asynchronous, active-high reset
- w_opcode5  in  5  latched IR[6:2]
- w_rd  in  5  latched IR[11:7]
- w_token  in  1  ALU branch-taken (rs1 != rs2)
- w_mem_ready  in  1  memory access completes this cycle
- w_mem_req  out  1  memory access request
- w_mem_sel  out  1  address select: 0 = PC (fetch), 1 = ALU result (data)
- w_mem_we  out  1  data-memory write enable
- w_ir_we  out  1  latch fetched word into IR
- w_pc_we  out  1  update PC this edge
- w_pc_sel  out  1  0 = PC+4, 1 = PC+imm
- w_rf_we  out  1  register-file write enable
- w_wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4 (link)
- w_state  out  3  current state encoding
- w_halt  out  1  halted (normal or error)
- w_error  out  1  memory timeout occurred
- r_cycle_count  out  32  running cycles since reset
- r_insn_count  out  32  retired instructions since reset

## Operation

- Decode from w_opcode5:
  - load = 00000; store = 01000; branch = 11000; jal = 11011.
  - All others retire through WB with wb_sel 0.
- States: IF=0, ID=1, EX=2, MA=3, WB=4, HALT=5, ERR=6; 7 unused, maps to IF.
- IF:
  - mem_req=1, mem_sel=0.
  - When w_mem_ready=1: ir_we=1, go to ID.
  - When w_mem_ready=0: stay.
- ID: no outputs; go to EX (RF read is combinational).
- EX, branch:
  - pc_we=1, pc_sel=w_token; retire; go to IF.
- EX, other opcodes:
  - load/store: go to MA.
  - everything else: go to WB.
- MA:
  - mem_req=1, mem_sel=1, mem_we=store.
  - On ready, store: pc_we=1, pc_sel=0, retire, go to IF.
  - On ready, load: go to WB.
- WB:
  - rf_we=1, pc_we=1.
  - wb_sel: 1 if load, 2 if jal, else 0.
  - pc_sel = jal.
  - Retire. Go to HALT if w_rd==30, else IF.
- HALT: all enables 0, w_halt=1; sticky until reset.
- ERR: all enables 0, w_halt=1, w_error=1; sticky until reset.
- Timeout:
  - 8-bit wait counter cleared on entry to IF or MA; increments each cycle in IF/MA without ready.
  - If the counter equals MEM_TIMEOUT-1 and ready=0, go to ERR.
  - Ready in that same cycle wins: the access completes normally.
- Outputs are combinational from state plus decode; ir_we, pc_we in MA, and mem-stage exit depend on w_mem_ready.
- w_mem_we is asserted for the whole MA dwell of a store. Memory commits on the ready cycle only.
- r_cycle_count: +1 every cycle not in HALT/ERR.
- r_insn_count: +1 on each retirement (pc_we cycle).
- Both counters wrap modulo 2^32.

## Timing

- Reset: state=IF, counters=0, wait counter=0.
- Outputs during reset: w_mem_req=1, w_mem_sel=0, w_state=0; all other outputs 0.
- Reset asserted mid-instruction: immediately forces IF.
  - mem_we drops combinationally; no RF/PC write occurs.
- Latency per instruction, ready tied high:
  - branch 3 cycles (IF,ID,EX).
  - store 4 (IF,ID,EX,MA).
  - ALU/U/jal 4 (IF,ID,EX,WB).
  - load 5.
- Each memory wait cycle adds 1.
- PC and RF write on the same edge at WB exit; jal link uses pre-update PC+4.
- First fetch request appears in the first cycle after reset deassertion; ir_we is asserted in that cycle if ready=1.

## Test plan

- addi x1,x0,5 (opcode5 00100, rd 1), ready=1:
  - w_state 0,1,2,4,0.
  - rf_we and pc_we high in cycle 4 only.
  - r_insn_count=1 and r_cycle_count=4 after 4 edges.
- Load (opcode5 0) with ready low 3 cycles in MA:
  - MA dwells 4 cycles; WB has wb_sel=1.
  - Total 8 cycles; insn_count=1.
- Branch, token=1 then token=0:
  - pc_we in EX with pc_sel=1, then pc_sel=0.
  - rf_we never high; 3 cycles each.
- Store:
  - mem_we=1 and mem_sel=1 in MA.
  - pc_we=1 on ready; rf_we=0.
- addi x30 (rd=30):
  - WB then HALT; w_halt=1.
  - Counters frozen for 10 further cycles; ready toggling ignored.
- Timeouts and reset:
  - ready held 0 in IF with MEM_TIMEOUT=16: ERR entered after 16 IF cycles, w_error=1.
  - Reset asserted mid-MA of a store: state=0 and mem_we=0 immediately.
  - Counters read 0 while reset is asserted.
